// File: rtl/game_pkg.sv
// +----------------------------------------------------------------------------+
// | game_pkg                                                                   |
// | Shared state encoding, display character codes, winner codes and the       |
// | per-position display character lookup for game_round_ctrl.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        SECRET_P1 = 3'd0,
        SECRET_P2 = 3'd1,
        GUESS_P1  = 3'd2,
        GUESS_P2  = 3'd3,
        WIN       = 3'd4,
        DRAW      = 3'd5
    } state_t;

    // Digits 0-9 encode as themselves; letters follow at 10 + alphabet index.
    localparam logic [5:0] CH_BLANK = 6'd63;
    localparam logic [5:0] CH_A     = 6'd10;
    localparam logic [5:0] CH_C     = 6'd12;
    localparam logic [5:0] CH_D     = 6'd13;
    localparam logic [5:0] CH_E     = 6'd14;
    localparam logic [5:0] CH_I     = 6'd18;
    localparam logic [5:0] CH_N     = 6'd23;
    localparam logic [5:0] CH_R     = 6'd27;
    localparam logic [5:0] CH_S     = 6'd28;
    localparam logic [5:0] CH_T     = 6'd29;
    localparam logic [5:0] CH_W     = 6'd32;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;
    localparam logic [1:0] WINNER_DRAW = 2'd3;

    function automatic logic [5:0] ch_digit(input logic [3:0] v);
        return (v < 4'd10) ? {2'b00, v} : CH_BLANK;
    endfunction

    function automatic logic [5:0] disp_char(
        input state_t     st,
        input int         pos,
        input int         last,
        input logic [3:0] b,
        input logic [3:0] c,
        input logic [1:0] win,
        input logic [7:0] rnd,
        input logic       show_rnd
    );
        logic [5:0] ch;
        logic [3:0] player;
        logic [7:0] rnd_ones;
        logic [7:0] rnd_tens;
        ch       = CH_BLANK;
        player   = (st == SECRET_P1 || st == GUESS_P1) ? 4'd1 : 4'd2;
        rnd_ones = rnd % 8'd10;
        rnd_tens = rnd / 8'd10;
        case (st)
            SECRET_P1, SECRET_P2: begin
                case (pos)
                    0:       ch = ch_digit(player);
                    1:       ch = CH_T;
                    2:       ch = CH_E;
                    3:       ch = CH_R;
                    4:       ch = CH_C;
                    5:       ch = CH_E;
                    6:       ch = CH_S;
                    default: ch = CH_BLANK;
                endcase
            end
            GUESS_P1, GUESS_P2: begin
                // Player digit sits in the leftmost display and wins any overlap.
                if (pos == last)               ch = ch_digit(player);
                else if (pos == 0)             ch = ch_digit(c);
                else if (pos == 1)             ch = ch_digit(b);
                else if (pos == 2 && show_rnd) ch = ch_digit(rnd_ones[3:0]);
                else if (pos == 3 && show_rnd) ch = ch_digit(rnd_tens[3:0]);
                else                           ch = CH_BLANK;
            end
            WIN: begin
                case (pos)
                    0:       ch = ch_digit({2'b00, win});
                    1:       ch = CH_N;
                    2:       ch = CH_I;
                    3:       ch = CH_W;
                    default: ch = CH_BLANK;
                endcase
            end
            DRAW: begin
                case (pos)
                    0:       ch = CH_W;
                    1:       ch = CH_A;
                    2:       ch = CH_R;
                    3:       ch = CH_D;
                    default: ch = CH_BLANK;
                endcase
            end
            default: ch = CH_BLANK;
        endcase
        return ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/detector_borda.sv
// +----------------------------------------------------------------------------+
// | detector_borda                                                             |
// | Rising-edge detector: o_rise is high for one cycle per 0->1 of i_sig.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_round_ctrl.sv
// +----------------------------------------------------------------------------+
// | game_round_ctrl                                                            |
// | Two-player bulls-and-cows round controller with character display output. |
// | Optional macro ROUND_LIMIT_EN: round counter that ends the game in a DRAW. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module game_round_ctrl
    import game_pkg::*;
#(
    parameter int  DIGITS     = 4,
    parameter int  DIGIT_W    = 4,
    parameter int  NUM_DISP   = 8,
    parameter int  MAX_ROUNDS = 10,
    localparam int CW         = $clog2(DIGITS + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          confirm,
    input  logic [DIGITS*DIGIT_W-1:0]     SW,
    output logic [NUM_DISP-1:0][5:0]      disp,
    output logic [CW-1:0]                 bulls,
    output logic [CW-1:0]                 cows,
    output logic [1:0]                    winner,
    output logic                          reject
);

    localparam int SW_W = DIGITS * DIGIT_W;

    if (DIGITS < 2 || DIGITS > 8) begin : g_chk_digits
        $error("game_round_ctrl: DIGITS must be in 2..8");
    end
    if (NUM_DISP < 4) begin : g_chk_disp
        $error("game_round_ctrl: NUM_DISP must be at least 4");
    end
    if (MAX_ROUNDS < 1) begin : g_chk_rounds
        $error("game_round_ctrl: MAX_ROUNDS must be at least 1");
    end

    state_t                   r_state;
    state_t                   w_next_state;
    logic [SW_W-1:0]          r_secret_p1;
    logic [SW_W-1:0]          r_secret_p2;
    logic [SW_W-1:0]          w_next_secret_p1;
    logic [SW_W-1:0]          w_next_secret_p2;
    logic [SW_W-1:0]          w_target;
    logic [CW-1:0]            r_bulls;
    logic [CW-1:0]            r_cows;
    logic [CW-1:0]            w_next_bulls;
    logic [CW-1:0]            w_next_cows;
    logic [CW-1:0]            w_bulls_cnt;
    logic [CW-1:0]            w_cows_cnt;
    logic [1:0]               r_winner;
    logic [1:0]               w_next_winner;
    logic                     r_reject;
    logic                     w_reject;
    logic                     w_valid;
    logic                     w_confirm_p;
    logic [NUM_DISP-1:0][5:0] r_disp;

`ifdef ROUND_LIMIT_EN
    localparam int RW = $clog2(MAX_ROUNDS + 1);
    logic [RW-1:0] r_round;
    logic [RW-1:0] w_next_round;
    logic [RW-1:0] w_round_inc;
    assign w_round_inc = r_round + RW'(1);
`endif

    detector_borda u_confirm_edge (
        .clk    (clock),
        .rst    (reset),
        .i_sig  (confirm),
        .o_rise (w_confirm_p)
    );

    always_comb begin
        w_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (SW[i*DIGIT_W +: DIGIT_W] == SW[j*DIGIT_W +: DIGIT_W]) begin
                    w_valid = 1'b0;
                end
            end
        end
    end

    // Player 1 guesses player 2's secret and vice versa.
    assign w_target = (r_state == GUESS_P1) ? r_secret_p2 : r_secret_p1;

    always_comb begin
        w_bulls_cnt = '0;
        w_cows_cnt  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (SW[i*DIGIT_W +: DIGIT_W] == w_target[j*DIGIT_W +: DIGIT_W]) begin
                    if (i == j) w_bulls_cnt = w_bulls_cnt + CW'(1);
                    else        w_cows_cnt  = w_cows_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_secret_p1 = r_secret_p1;
        w_next_secret_p2 = r_secret_p2;
        w_next_bulls     = r_bulls;
        w_next_cows      = r_cows;
        w_next_winner    = r_winner;
        w_reject         = 1'b0;
`ifdef ROUND_LIMIT_EN
        w_next_round     = r_round;
`endif
        if (w_confirm_p) begin
            case (r_state)
                SECRET_P1: begin
                    if (w_valid) begin
                        w_next_secret_p1 = SW;
                        w_next_state     = SECRET_P2;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                SECRET_P2: begin
                    if (w_valid) begin
                        w_next_secret_p2 = SW;
                        w_next_state     = GUESS_P1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
                GUESS_P1, GUESS_P2: begin
                    if (!w_valid) begin
                        w_reject = 1'b1;
                    end else begin
                        w_next_bulls = w_bulls_cnt;
                        w_next_cows  = w_cows_cnt;
                        if (w_bulls_cnt == CW'(DIGITS)) begin
                            w_next_state  = WIN;
                            w_next_winner = (r_state == GUESS_P1) ? WINNER_P1 : WINNER_P2;
                        end else if (r_state == GUESS_P1) begin
                            w_next_state = GUESS_P2;
                        end else begin
`ifdef ROUND_LIMIT_EN
                            w_next_round = w_round_inc;
                            if (w_round_inc == RW'(MAX_ROUNDS)) begin
                                w_next_state  = DRAW;
                                w_next_winner = WINNER_DRAW;
                            end else begin
                                w_next_state = GUESS_P1;
                            end
`else
                            w_next_state = GUESS_P1;
`endif
                        end
                    end
                end
                WIN, DRAW: begin
                    w_next_state     = SECRET_P1;
                    w_next_secret_p1 = '0;
                    w_next_secret_p2 = '0;
                    w_next_bulls     = '0;
                    w_next_cows      = '0;
                    w_next_winner    = WINNER_NONE;
`ifdef ROUND_LIMIT_EN
                    w_next_round     = '0;
`endif
                end
                default: w_next_state = SECRET_P1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= SECRET_P1;
            r_secret_p1 <= '0;
            r_secret_p2 <= '0;
            r_bulls     <= '0;
            r_cows      <= '0;
            r_winner    <= WINNER_NONE;
            r_reject    <= 1'b0;
`ifdef ROUND_LIMIT_EN
            r_round     <= '0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_secret_p1 <= w_next_secret_p1;
            r_secret_p2 <= w_next_secret_p2;
            r_bulls     <= w_next_bulls;
            r_cows      <= w_next_cows;
            r_winner    <= w_next_winner;
            r_reject    <= w_reject;
`ifdef ROUND_LIMIT_EN
            r_round     <= w_next_round;
`endif
        end
    end

    // Display follows the registered state, so it trails a transition by a cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DISP; i++) begin
                r_disp[i] <= CH_BLANK;
            end
        end else begin
            for (int i = 0; i < NUM_DISP; i++) begin
`ifdef ROUND_LIMIT_EN
                r_disp[i] <= disp_char(r_state, i, NUM_DISP - 1, 4'(r_bulls), 4'(r_cows),
                                       r_winner, 8'(r_round), 1'b1);
`else
                r_disp[i] <= disp_char(r_state, i, NUM_DISP - 1, 4'(r_bulls), 4'(r_cows),
                                       r_winner, 8'd0, 1'b0);
`endif
            end
        end
    end

    assign disp   = r_disp;
    assign bulls  = r_bulls;
    assign cows   = r_cows;
    assign winner = r_winner;
    assign reject = r_reject;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_game_round_ctrl                                                         |
// | Directed self-checking bench for game_round_ctrl.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_game_round_ctrl;

    localparam logic [5:0] K_BL = 6'd63;
    localparam logic [5:0] K_A  = 6'd10;
    localparam logic [5:0] K_C  = 6'd12;
    localparam logic [5:0] K_D  = 6'd13;
    localparam logic [5:0] K_E  = 6'd14;
    localparam logic [5:0] K_I  = 6'd18;
    localparam logic [5:0] K_N  = 6'd23;
    localparam logic [5:0] K_R  = 6'd27;
    localparam logic [5:0] K_S  = 6'd28;
    localparam logic [5:0] K_T  = 6'd29;
    localparam logic [5:0] K_W  = 6'd32;

    logic             clock;
    logic             reset;
    logic             confirm;
    logic [15:0]      SW;
    logic [7:0][5:0]  disp;
    logic [2:0]       bulls;
    logic [2:0]       cows;
    logic [1:0]       winner;
    logic             reject;

    int n_total = 0;
    int n_bad   = 0;

    game_round_ctrl #(
        .DIGITS     (4),
        .DIGIT_W    (4),
        .NUM_DISP   (8),
        .MAX_ROUNDS (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .confirm (confirm),
        .SW      (SW),
        .disp    (disp),
        .bulls   (bulls),
        .cows    (cows),
        .winner  (winner),
        .reject  (reject)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] dsp(input logic [5:0] c7, c6, c5, c4, c3, c2, c1, c0);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [47:0] d_secret(input logic [5:0] p);
        return dsp(K_BL, K_S, K_E, K_C, K_R, K_E, K_T, p);
    endfunction

    function automatic logic [47:0] d_guess(input logic [5:0] p, b, c, input int rnd);
        logic [5:0] tens;
        logic [5:0] ones;
`ifdef ROUND_LIMIT_EN
        tens = 6'(rnd / 10);
        ones = 6'(rnd % 10);
`else
        tens = K_BL;
        ones = K_BL;
        if (rnd < 0) tens = K_BL;
`endif
        return dsp(p, K_BL, K_BL, K_BL, tens, ones, b, c);
    endfunction

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        SW      = v;
        confirm = 1'b1;
        @(negedge clock);
        confirm = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        confirm = 1'b0;
        SW      = 16'h0000;
        #1;
        check("rst_disp",   disp,   {48{1'b1}});
        check("rst_bulls",  bulls,  0);
        check("rst_winner", winner, 0);
        check("rst_reject", reject, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_disp", disp, d_secret(6'd1));

        // Repeated digit must be refused without moving on
        press(16'h1123);
        check("rej_pulse", reject, 1);
        @(negedge clock);
        check("rej_clear", reject, 0);
        check("rej_disp",  disp, d_secret(6'd1));

        press(16'h1234);
        check("s1_reject", reject, 0);
        @(negedge clock);
        check("s1_disp", disp, d_secret(6'd2));
        press(16'h5678);
        @(negedge clock);
        check("s2_disp", disp, d_guess(6'd1, 6'd0, 6'd0, 0));

        press(16'h8765);
        check("g1_bulls", bulls, 0);
        check("g1_cows",  cows,  4);
        @(negedge clock);
        check("g1_disp", disp, d_guess(6'd2, 6'd0, 6'd4, 0));

        press(16'h1243);
        check("g2_bulls", bulls, 2);
        check("g2_cows",  cows,  2);
        @(negedge clock);
        check("g2_disp", disp, d_guess(6'd1, 6'd2, 6'd2, 1));

        press(16'h5678);
        check("win_bulls",  bulls,  4);
        check("win_winner", winner, 1);
        check("win_disp_lag", disp, d_guess(6'd1, 6'd2, 6'd2, 1));
        @(negedge clock);
        check("win_disp", disp, dsp(K_BL, K_BL, K_BL, K_BL, K_W, K_I, K_N, 6'd1));

        // From WIN, any confirm restarts; SW content is irrelevant
        press(16'h1123);
        check("new_reject", reject, 0);
        check("new_winner", winner, 0);
        check("new_bulls",  bulls,  0);
        @(negedge clock);
        check("new_disp", disp, d_secret(6'd1));

        @(negedge clock);
        SW      = 16'h1234;
        confirm = 1'b1;
        repeat (20) @(negedge clock);
        confirm = 1'b0;
        check("hold_disp", disp, d_secret(6'd2));
        press(16'h9876);
        @(negedge clock);
        check("hold_next", disp, d_guess(6'd1, 6'd0, 6'd0, 0));

        press(16'h9867);
        check("p1_bulls", bulls, 2);
        check("p1_cows",  cows,  2);
        @(negedge clock);
        check("p2_disp", disp, d_guess(6'd2, 6'd2, 6'd2, 0));

        // Asynchronous reset while in GUESS_P2
        #2;
        reset = 1'b1;
        #1;
        check("arst_bulls",  bulls,  0);
        check("arst_cows",   cows,   0);
        check("arst_winner", winner, 0);
        check("arst_disp",   disp,   {48{1'b1}});
        @(negedge clock);
        reset = 1'b0;
        press(16'h1234);
        @(negedge clock);
        check("post_rst_disp", disp, d_secret(6'd2));

        press(16'h5678);
        press(16'h8765);
        press(16'h1243);
        press(16'h8765);
        press(16'h1243);
        check("last_bulls", bulls, 2);
`ifdef ROUND_LIMIT_EN
        check("limit_winner", winner, 3);
        @(negedge clock);
        check("limit_disp", disp, dsp(K_BL, K_BL, K_BL, K_BL, K_D, K_R, K_A, K_W));
`else
        check("nolimit_winner", winner, 0);
        @(negedge clock);
        check("nolimit_disp", disp, d_guess(6'd1, 6'd2, 6'd2, 0));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of digits in a secret or guess (2..8).
REQ-002 SHALL have parameter DIGIT_W, default 4, meaning bits per digit.
REQ-003 SHALL have parameter NUM_DISP, default 8, meaning number of 6-bit character displays (NUM_DISP >= 4).
REQ-004 SHALL have parameter MAX_ROUNDS, default 10, meaning round limit, used only under ROUND_LIMIT_EN.
REQ-005 SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port confirm, input, 1 bit: raw confirm button.
REQ-008 SHALL have port SW, input, DIGITS*DIGIT_W bits: digit entry, digit i = SW[i*DIGIT_W +: DIGIT_W].
REQ-009 SHALL have port disp, output, NUM_DISP x 6 bits: character codes, index 0 rightmost.
REQ-010 SHALL have port bulls, output, $clog2(DIGITS+1) bits: bulls of the last accepted guess.
REQ-011 SHALL have port cows, output, $clog2(DIGITS+1) bits: cows of the last accepted guess.
REQ-012 SHALL have port winner, output, 2 bits: 0 none, 1 player 1, 2 player 2, 3 draw.
REQ-013 SHALL have port reject, output, 1 bit: one-cycle pulse when a confirmed entry is invalid.

Function
REQ-014 SHALL use a confirm pulse that is high for exactly one cycle per rising edge of confirm.
REQ-015 SHALL treat an entry as valid only when all DIGITS digits are pairwise distinct.
REQ-016 On an invalid entry, SHALL pulse reject in the cycle after the confirm pulse, leaving state and registers unchanged.
REQ-017 SHALL implement the states SECRET_P1, SECRET_P2, GUESS_P1, GUESS_P2, WIN and DRAW.
REQ-018 SECRET_P1: on a valid entry, SHALL store SW as secret_p1 and go to SECRET_P2.
REQ-019 SECRET_P2: on a valid entry, SHALL store SW as secret_p2 and go to GUESS_P1.
REQ-020 GUESS_P1: on a valid entry, SHALL compare the guess against secret_p2.
REQ-021 GUESS_P2: on a valid entry, SHALL compare the guess against secret_p1.
REQ-022 SHALL count bulls as positions where the digits are equal.
REQ-023 SHALL count cows as guess digits that equal a secret digit in a different position.
REQ-024 SHALL register bulls and cows in the same cycle as the state transition.
REQ-025 When bulls == DIGITS, SHALL go to WIN with winner set to the guessing player.
REQ-026 When bulls < DIGITS, SHALL pass the turn to the other player.
REQ-027 WIN/DRAW: a confirm pulse SHALL clear the secrets, bulls, cows and winner and go to SECRET_P1; SW is ignored.
REQ-028 disp SHALL be registered from the current state and shall therefore lag a state change by one cycle.
REQ-029 disp per state: the SECRET_* states SHALL show the "SECRET" prompt plus the player digit; the GUESS_* states SHALL show the player digit plus the last bulls/cows in disp[1:0]; WIN SHALL show "WIN" plus the player digit; DRAW SHALL show "DRAW".
REQ-030 Any disp positions beyond those listed in REQ-029 SHALL show the blank code.

Reset
REQ-031 Reset SHALL asynchronously set: state SECRET_P1, secrets 0, bulls 0, cows 0, winner 0, reject 0, round count 0, and every disp to the blank code.
REQ-032 Reset asserted mid-game SHALL discard all game data; the first confirm after release SHALL be treated as a secret entry for player 1.

Configuration
REQ-033 With ROUND_LIMIT_EN defined, a round counter SHALL increment on each non-winning GUESS_P2 entry.
REQ-034 With ROUND_LIMIT_EN defined, reaching MAX_ROUNDS SHALL take the FSM to DRAW with winner=3, and GUESS_* displays SHALL show the round count in disp[3:2].
REQ-035 Without ROUND_LIMIT_EN, SHALL have no counter, SHALL never enter DRAW, and SHALL never set winner=3.

Structure
REQ-036 Package game_pkg SHALL hold the state_t enum, the 6-bit character-code constants (blank, digits, prompt letters) and the winner encodings.
REQ-037 Edge detection SHALL reuse the existing detector_borda sub-module; no other sub-module is used.

Verification
REQ-038 Secret with SW=16'h1123 -> reject pulses once, state stays SECRET_P1.
REQ-039 Secrets 16'h1234/16'h5678, P1 guess 16'h8765 -> bulls=0, cows=4, state GUESS_P2.
REQ-040 Same secrets, P1 guess 16'h5678 -> bulls=4, winner=1, WIN, disp shows "WIN" with digit 1 one cycle later.
REQ-041 confirm held high for 20 cycles in SECRET_P1 -> exactly one entry accepted.
REQ-042 Reset asserted during GUESS_P2 -> all outputs at reset values immediately, without waiting for a clock edge.
REQ-043 ROUND_LIMIT_EN, MAX_ROUNDS=2, four non-winning guesses -> DRAW, winner=3.
